// File: rtl/immediate_generator_stage.sv
// Registered RISC-V immediate decoder: one instruction per cycle, result one cycle after accept.
// Backpressure: in_ready drops while a result is held and out_ready is low; flush drops held and incoming work.
module immediate_generator_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_data,
    output logic [2:0]       imm_fmt,
    output logic             imm_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    localparam bit IS_RV64 = (XLEN == 64);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } dec_t;

    dec_t        dec;
    logic [31:0] imm32;
    logic [31:0] ins;
    logic        accept;

    assign ins      = instruction;
    assign in_ready = !reset && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Every immediate fits in 32 signed bits, so decode to 32 and sign-extend once.
    always_comb begin
        imm32       = '0;
        dec.fmt     = FMT_ILL;
        dec.illegal = 1'b1;
        case (ins[6:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
                imm32       = {{20{ins[31]}}, ins[31:20]};
                dec.fmt     = FMT_I;
                dec.illegal = 1'b0;
            end
            OP_IMM32: begin
                if (IS_RV64) begin
                    imm32       = {{20{ins[31]}}, ins[31:20]};
                    dec.fmt     = FMT_I;
                    dec.illegal = 1'b0;
                end
            end
            OP_STORE: begin
                imm32       = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                dec.fmt     = FMT_S;
                dec.illegal = 1'b0;
            end
            OP_BRANCH: begin
                imm32       = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                dec.fmt     = FMT_B;
                dec.illegal = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                imm32       = {ins[31:12], 12'b0};
                dec.fmt     = FMT_U;
                dec.illegal = 1'b0;
            end
            OP_JAL: begin
                imm32       = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                dec.fmt     = FMT_J;
                dec.illegal = 1'b0;
            end
            OP_OP: begin
                dec.fmt     = FMT_R;
                dec.illegal = 1'b0;
            end
            OP_OP32: begin
                if (IS_RV64) begin
                    dec.fmt     = FMT_R;
                    dec.illegal = 1'b0;
                end
            end
            default: ;
        endcase
        dec.imm = XLEN'($signed(imm32));
    end

    // Flush only clears valid; data registers are allowed to go stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            imm_data      <= '0;
            imm_fmt       <= FMT_R;
            imm_illegal   <= 1'b0;
            illegal_count <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            imm_data    <= dec.imm;
            imm_fmt     <= dec.fmt;
            imm_illegal <= dec.illegal;
            if (dec.illegal && (illegal_count != '1))
                illegal_count <= illegal_count + CNT_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_immediate_generator_stage.sv
// Drives an RV64/16-bit-counter instance and an RV32/2-bit-counter instance with identical stimulus.
module tb_immediate_generator_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] instruction;
    logic        flush;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_ill;
    logic [63:0] a_imm;
    logic [2:0]  a_fmt;
    logic [15:0] a_cnt;

    logic        b_in_ready, b_out_valid, b_ill;
    logic [31:0] b_imm;
    logic [2:0]  b_fmt;
    logic [1:0]  b_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    bit check_en = 0;

    immediate_generator_stage #(.XLEN(64), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .instruction(instruction), .flush(flush), .out_valid(a_out_valid),
        .out_ready(out_ready), .imm_data(a_imm), .imm_fmt(a_fmt),
        .imm_illegal(a_ill), .illegal_count(a_cnt)
    );

    immediate_generator_stage #(.XLEN(32), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .instruction(instruction), .flush(flush), .out_valid(b_out_valid),
        .out_ready(out_ready), .imm_data(b_imm), .imm_fmt(b_fmt),
        .imm_illegal(b_ill), .illegal_count(b_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Immediate as a signed integer, computed from bit weights (sign bit carries negative weight).
    function automatic void ref_decode(input logic [31:0] i, input bit rv64,
                                       output longint v, output int fmt);
        v   = 0;
        fmt = 7;
        case (i[6:0])
            7'h03, 7'h13, 7'h67: fmt = 1;
            7'h1B:               fmt = rv64 ? 1 : 7;
            7'h23:               fmt = 2;
            7'h63:               fmt = 3;
            7'h37, 7'h17:        fmt = 4;
            7'h6F:               fmt = 5;
            7'h33:               fmt = 0;
            7'h3B:               fmt = rv64 ? 0 : 7;
            default:             fmt = 7;
        endcase
        case (fmt)
            1: v = longint'(i[30:20]) - (i[31] ? 64'sd2048 : 64'sd0);
            2: v = longint'(i[30:25]) * 32 + longint'(i[11:7]) - (i[31] ? 64'sd2048 : 64'sd0);
            3: v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2
                   - (i[31] ? 64'sd4096 : 64'sd0);
            4: v = longint'(i[30:12]) * 4096 - (i[31] ? 64'sh8000_0000 : 64'sd0);
            5: v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2
                   - (i[31] ? 64'sd1048576 : 64'sd0);
            default: v = 0;
        endcase
    endfunction

    // Reference state, advanced on each rising edge from the inputs presented before it.
    bit          m_valid = 0;
    logic [63:0] m_imm_a = '0;
    logic [31:0] m_imm_b = '0;
    int          m_fmt_a = 0, m_fmt_b = 0;
    int          m_cnt_a = 0, m_cnt_b = 0;

    always @(posedge clk) begin
        longint va, vb;
        int     fa, fb;
        bit     acc;
        if (reset) begin
            m_valid = 0; m_imm_a = '0; m_imm_b = '0;
            m_fmt_a = 0; m_fmt_b = 0; m_cnt_a = 0; m_cnt_b = 0;
        end else begin
            acc = in_valid && (!m_valid || out_ready);
            if (flush) begin
                m_valid = 0;
            end else if (acc) begin
                ref_decode(instruction, 1'b1, va, fa);
                ref_decode(instruction, 1'b0, vb, fb);
                m_valid = 1;
                m_imm_a = va;
                m_imm_b = vb[31:0];
                m_fmt_a = fa;
                m_fmt_b = fb;
                if (fa == 7) m_cnt_a = (m_cnt_a < 65535) ? m_cnt_a + 1 : 65535;
                if (fb == 7) m_cnt_b = (m_cnt_b < 3) ? m_cnt_b + 1 : 3;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("a_in_ready", a_in_ready, !reset && (!m_valid || out_ready));
            chk("b_in_ready", b_in_ready, !reset && (!m_valid || out_ready));
            chk("a_out_valid", a_out_valid, m_valid);
            chk("b_out_valid", b_out_valid, m_valid);
            chk("a_count", a_cnt, m_cnt_a);
            chk("b_count", b_cnt, m_cnt_b);
            if (m_valid) begin
                chk("a_imm", a_imm, m_imm_a);
                chk("a_fmt", a_fmt, m_fmt_a);
                chk("a_illegal", a_ill, m_fmt_a == 7);
                chk("b_imm", b_imm, m_imm_b);
                chk("b_fmt", b_fmt, m_fmt_b);
                chk("b_illegal", b_ill, m_fmt_b == 7);
            end
        end
    end

    // Present inputs, then return just after the edge that consumes them.
    task automatic cyc(input bit v, input logic [31:0] ins, input bit fl, input bit ordy, input bit rst);
        in_valid    = v;
        instruction = ins;
        flush       = fl;
        out_ready   = ordy;
        reset       = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        longint     pv;
        int         pf;
        logic [6:0] ops [14];
        int         exp_b [5];
        logic [31:0] rins;

        ops = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37,
                7'h17, 7'h6F, 7'h33, 7'h3B, 7'h00, 7'h7F, 7'h0F};
        exp_b = '{1, 2, 3, 3, 3};

        // Pin the reference decoder against hand-computed values.
        ref_decode(32'hFFF00093, 1'b1, pv, pf);
        chk("model_addi", pv, 64'hFFFF_FFFF_FFFF_FFFF);
        ref_decode(32'hFE000CE3, 1'b1, pv, pf);
        chk("model_beq", pv, 64'hFFFF_FFFF_FFFF_FFF8);
        ref_decode(32'h800000B7, 1'b1, pv, pf);
        chk("model_lui", pv, 64'hFFFF_FFFF_8000_0000);
        ref_decode(32'hFFDFF06F, 1'b1, pv, pf);
        chk("model_jal", pv, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("model_jal_fmt", pf, 5);

        cyc(0, 32'h0, 0, 0, 1);
        cyc(0, 32'h0, 0, 0, 1);
        check_en = 1;
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_imm", a_imm, 0);
        chk("rst_fmt", a_fmt, 0);
        chk("rst_cnt", a_cnt, 0);

        cyc(1, 32'hFFF00093, 0, 1, 0);
        chk("addi_valid", a_out_valid, 1);
        chk("addi_imm", a_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_fmt", a_fmt, 1);
        chk("addi_ill", a_ill, 0);

        cyc(1, 32'hFE112E23, 0, 1, 0);
        chk("sw_imm", a_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("sw_fmt", a_fmt, 2);
        cyc(1, 32'hFE000CE3, 0, 1, 0);
        chk("beq_valid", a_out_valid, 1);
        chk("beq_imm", a_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("beq_fmt", a_fmt, 3);
        cyc(1, 32'h800000B7, 0, 1, 0);
        chk("lui_valid", a_out_valid, 1);
        chk("lui_imm", a_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui_fmt", a_fmt, 4);
        chk("lui_imm32", b_imm, 32'h8000_0000);

        cyc(0, 32'h0, 0, 1, 0);
        chk("drain_valid", a_out_valid, 0);
        cyc(1, 32'h00500113, 0, 0, 0);
        chk("bp_first_imm", a_imm, 5);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 32'h06400193, 0, 0, 0);
            chk("bp_hold_imm", a_imm, 5);
            chk("bp_hold_valid", a_out_valid, 1);
            chk("bp_in_ready", a_in_ready, 0);
        end
        cyc(1, 32'h06400193, 0, 1, 0);
        chk("bp_second_imm", a_imm, 100);
        chk("bp_second_valid", a_out_valid, 1);
        cyc(0, 32'h0, 0, 1, 0);
        chk("bp_drained", a_out_valid, 0);

        cyc(1, 32'h0, 0, 1, 0);
        chk("ill_flag", a_ill, 1);
        chk("ill_fmt", a_fmt, 7);
        chk("ill_imm", a_imm, 0);
        chk("ill_cnt", a_cnt, 1);
        cyc(1, 32'h0, 1, 1, 0);
        chk("flush_valid", a_out_valid, 0);
        chk("flush_cnt", a_cnt, 1);

        cyc(0, 32'h0, 0, 1, 1);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 32'h0, 0, 1, 0);
            chk("sat_cnt_b", b_cnt, exp_b[k]);
            chk("sat_cnt_a", a_cnt, k + 1);
        end

        cyc(1, 32'h0010009B, 0, 1, 0);
        chk("addiw_b_fmt", b_fmt, 7);
        chk("addiw_b_ill", b_ill, 1);
        chk("addiw_a_fmt", a_fmt, 1);
        chk("addiw_a_imm", a_imm, 1);
        cyc(1, 32'h800000B7, 1, 0, 1);
        chk("midrst_valid", b_out_valid, 0);
        chk("midrst_imm", b_imm, 0);
        chk("midrst_fmt", b_fmt, 0);
        chk("midrst_ill", b_ill, 0);
        chk("midrst_cnt", b_cnt, 0);

        for (int n = 0; n < 3000; n++) begin
            rins      = $urandom();
            rins[6:0] = ops[$urandom_range(0, 13)];
            cyc($urandom_range(0, 9) < 7, rins, $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) < 7, $urandom_range(0, 63) == 0);
        end
        cyc(0, 32'h0, 0, 1, 0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
